// File: rtl/devil_sweep_scheduler_pkg.sv
// Shared definitions for the sweep scheduler: FSM encodings, default line
// stride and the watchdog limit.
package devil_sweep_scheduler_pkg;

    localparam int          SWEEP_STATE_W  = 3;
    localparam int          LINE_BYTES_DEF = 64;
    localparam logic [15:0] WDOG_LIMIT     = 16'hFFFF;

    typedef enum logic [SWEEP_STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/devil_sweep_scheduler_gap.sv
// devil_gap_timer: loadable down-counter with a zero flag. Used for the
// inter-line gap; kept generic so the passive path can reuse it.
module devil_gap_timer #(
    parameter int W = 32
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; the counter saturates at zero.
    always_ff @(posedge gclk) begin
        if (!grst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/devil_sweep_scheduler.sv
// devil_sweep_scheduler: walks the active engine over an address range one
// cache line at a time: trigger, wait for reply, let the engine re-arm,
// programmable gap, next line.
// Optional feature: define SWEEP_WATCHDOG_EN to add a 16-bit watchdog on
// the wait/release states that aborts a hung sweep.
module devil_sweep_scheduler
    import devil_sweep_scheduler_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int LINE_BYTES         = LINE_BYTES_DEF,
    parameter int SWEEP_STATE_SIZE   = SWEEP_STATE_W
) (
    input  logic                          ace_aclk,
    input  logic                          ace_aresetn,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_delay,
    input  logic                          i_engine_busy,
    input  logic                          i_engine_reply,
    output logic                          o_trigger,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_line_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_lines_done,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_aborted,
    output logic                          o_timeout
);

    localparam int DW      = C_S_AXI_DATA_WIDTH;
    localparam int AW      = C_ACE_ADDR_WIDTH;
    localparam int LB_LOG2 = $clog2(LINE_BYTES);

    logic [SWEEP_STATE_SIZE-1:0] state_r;
    sweep_state_t                state, nxt;

    logic [DW:0]   lines_calc;
    logic [DW:0]   remaining;
    logic [DW-1:0] delay_q;
    logic [AW-1:0] line_addr;
    logic [DW-1:0] lines_done;
    logic          stop_pend, aborted, timeout;
    logic          stop_eff, start_ok, rel_exit, end_abort;
    logic          gap_load, gap_dec, gap_zero;
    logic          wdog_fire;
    logic          unused_base_bits;

    assign state = sweep_state_t'(state_r);

    // Widened by one bit so size near 2^DW cannot wrap to zero lines.
    assign lines_calc = ({1'b0, i_addr_size} + (DW+1)'(LINE_BYTES - 1)) >> LB_LOG2;
    assign start_ok   = i_start && (state == S_IDLE);
    assign stop_eff   = stop_pend || i_stop;

    // Line offset bits of the base are dropped by design.
    assign unused_base_bits = ^i_base_addr[LB_LOG2-1:0];

    devil_gap_timer #(.W(DW)) u_gap (
        .gclk     (ace_aclk),
        .grst_n   (ace_aresetn),
        .load     (gap_load),
        .load_val (delay_q - DW'(1)),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    // Next-state logic; the watchdog overrides everything when it fires.
    always_comb begin
        nxt       = state;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        rel_exit  = 1'b0;
        end_abort = 1'b0;
        case (state)
            S_IDLE:
                if (i_start)
                    nxt = (lines_calc == '0) ? S_DONE : S_ISSUE;
            S_ISSUE:
                nxt = S_WAIT;
            S_WAIT:
                if (i_engine_reply)
                    nxt = S_RELEASE;
            S_RELEASE:
                // Engine must go idle before the next trigger can be seen.
                if (!i_engine_busy) begin
                    rel_exit = 1'b1;
                    if (remaining == '0 || stop_eff) begin
                        nxt       = S_DONE;
                        end_abort = stop_eff;
                    end else if (delay_q == '0) begin
                        nxt = S_ISSUE;
                    end else begin
                        gap_load = 1'b1;
                        nxt      = S_GAP;
                    end
                end
            S_GAP:
                if (stop_eff) begin
                    nxt       = S_DONE;
                    end_abort = 1'b1;
                end else if (gap_zero) begin
                    nxt = S_ISSUE;
                end else begin
                    gap_dec = 1'b1;
                end
            S_DONE:
                nxt = S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
        if (wdog_fire)
            nxt = S_DONE;
    end

`ifdef SWEEP_WATCHDOG_EN
    logic [15:0] wdog;

    assign wdog_fire = ((state == S_WAIT) || (state == S_RELEASE)) && (wdog == WDOG_LIMIT);

    // Counts time spent in a single wait/release visit; restarts on any state change.
    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn)
            wdog <= '0;
        else if (nxt != state)
            wdog <= '0;
        else if ((state == S_WAIT) || (state == S_RELEASE))
            wdog <= wdog + 16'd1;
        else
            wdog <= '0;
    end
`else
    assign wdog_fire = 1'b0;
`endif

    // State register plus sweep context latched at start.
    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            state_r    <= SWEEP_STATE_SIZE'(S_IDLE);
            line_addr  <= '0;
            remaining  <= '0;
            delay_q    <= '0;
            lines_done <= '0;
            stop_pend  <= 1'b0;
            aborted    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r <= SWEEP_STATE_SIZE'(nxt);
            if (start_ok) begin
                line_addr  <= {i_base_addr[AW-1:LB_LOG2], {LB_LOG2{1'b0}}};
                remaining  <= lines_calc;
                delay_q    <= i_delay;
                lines_done <= '0;
                stop_pend  <= 1'b0;
                aborted    <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                if (o_busy && i_stop)
                    stop_pend <= 1'b1;
                if (state == S_WAIT && i_engine_reply) begin
                    lines_done <= lines_done + DW'(1);
                    remaining  <= remaining - (DW+1)'(1);
                end
                if (rel_exit)
                    line_addr <= line_addr + AW'(LINE_BYTES);
                if (end_abort)
                    aborted <= 1'b1;
                if (wdog_fire) begin
                    aborted <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

    // Trigger is gated by reset so it falls in the very cycle reset arrives.
    assign o_trigger    = ace_aresetn && ((state == S_ISSUE) || (state == S_WAIT));
    assign o_line_addr  = line_addr;
    assign o_lines_done = lines_done;
    assign o_busy       = (state != S_IDLE) && (state != S_DONE);
    assign o_done       = (state == S_DONE);
    assign o_aborted    = aborted;
    assign o_timeout    = timeout;

endmodule

// File: tb/tb_devil_sweep_scheduler.sv
// Self-checking bench for devil_sweep_scheduler with a behavioural engine
// and a queue of expected line addresses.
module tb_devil_sweep_scheduler;

    logic        ace_aclk = 0;
    logic        ace_aresetn;
    logic        i_start, i_stop;
    logic [43:0] i_base_addr;
    logic [31:0] i_addr_size, i_delay;
    logic        o_trigger, o_busy, o_done, o_aborted, o_timeout;
    logic [43:0] o_line_addr;
    logic [31:0] o_lines_done;

    logic eng_busy, eng_reply, eng_armed;
    int   eng_cnt, eng_hcnt;
    int   eng_lat  = 5;
    int   eng_hold = 0;
    bit   eng_en   = 1;

    int total = 0;
    int bad   = 0;
    logic [43:0] exp_q[$];

    always #5 ace_aclk = ~ace_aclk;

    devil_sweep_scheduler dut (
        .ace_aclk       (ace_aclk),
        .ace_aresetn    (ace_aresetn),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .i_base_addr    (i_base_addr),
        .i_addr_size    (i_addr_size),
        .i_delay        (i_delay),
        .i_engine_busy  (eng_busy),
        .i_engine_reply (eng_reply),
        .o_trigger      (o_trigger),
        .o_line_addr    (o_line_addr),
        .o_lines_done   (o_lines_done),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_aborted      (o_aborted),
        .o_timeout      (o_timeout)
    );

    // Engine model: starts on a trigger once re-armed by a low trigger,
    // replies eng_lat cycles later, stays busy eng_hold cycles after reply.
    always @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            eng_busy <= 0; eng_reply <= 0; eng_armed <= 1; eng_cnt <= 0; eng_hcnt <= 0;
        end else begin
            eng_reply <= 0;
            if (eng_hcnt != 0) begin
                eng_hcnt <= eng_hcnt - 1;
                if (eng_hcnt == 1) eng_busy <= 0;
            end
            if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    eng_reply <= 1;
                    if (eng_hold == 0) eng_busy <= 0;
                    else eng_hcnt <= eng_hold;
                end
            end else if (o_trigger && eng_armed && eng_en && !eng_busy) begin
                eng_busy <= 1; eng_armed <= 0; eng_cnt <= eng_lat;
            end else if (!o_trigger) begin
                eng_armed <= 1;
            end
        end
    end

    // Drive a start pulse and queue expected line addresses (capped at 16).
    task automatic start_sweep(input logic [43:0] base, input logic [31:0] size, input logic [31:0] dly);
        logic [63:0] nlines;
        logic [43:0] a;
        nlines = ({32'd0, size} + 64'd63) / 64;
        a = base & ~44'h3F;
        for (int k = 0; k < 16 && k < int'(nlines); k++) begin
            exp_q.push_back(a);
            a = a + 44'd64;
        end
        i_base_addr = base; i_addr_size = size; i_delay = dly; i_start = 1;
        @(negedge ace_aclk);
        i_start = 0;
        // Scrambled config afterwards must not affect the running sweep.
        i_base_addr = 44'h555_5555_5555; i_addr_size = 32'hFFFF_FFFF; i_delay = 32'd77;
    endtask

    // Step the sweep to completion checking each trigger rise against the queue.
    task automatic run_sweep(input string nm, input int stop_trig, input int stop_since,
                             input int restart_since, output int rises, output int dones,
                             output int last_low);
        int since, low, post;
        bit prev;
        logic [43:0] e;
        rises = 0; dones = 0; last_low = -1; since = 0; low = 0; post = 0; prev = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            i_stop = 0; i_start = 0;
            if (o_trigger && !prev) begin
                rises++;
                if (rises > 1) last_low = low;
                low = 0; since = 0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_trigger: got addr %h want none", nm, o_line_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (o_line_addr !== e) begin
                        bad++;
                        $display("FAIL %s line_addr: got %h want %h", nm, o_line_addr, e);
                    end
                end
            end else begin
                since++;
            end
            if (!o_trigger && rises > 0) low++;
            if (stop_trig != 0 && rises == stop_trig && since == stop_since) i_stop = 1;
            if (restart_since >= 0 && rises == 1 && since == restart_since) begin
                i_start = 1; i_base_addr = 44'h0AB_CDEF_0000; i_addr_size = 32'd640;
            end
            if (o_done) dones++;
            prev = o_trigger;
            if (dones > 0) post++;
            if (post > 8) break;
            @(negedge ace_aclk);
        end
        i_stop = 0; i_start = 0;
        total++;
        if (post == 0) begin
            bad++;
            $display("FAIL %s done_timeout: got no o_done want o_done within 4000 cycles", nm);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic test_reset;
        ace_aresetn = 0; i_start = 0; i_stop = 0;
        i_base_addr = 0; i_addr_size = 0; i_delay = 0;
        repeat (3) @(negedge ace_aclk);
        total++;
        if ({o_trigger, o_busy, o_done, o_aborted, o_timeout, o_line_addr, o_lines_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got trig=%b busy=%b done=%b ab=%b to=%b addr=%h n=%0d want all 0",
                     o_trigger, o_busy, o_done, o_aborted, o_timeout, o_line_addr, o_lines_done);
        end
        ace_aresetn = 1;
        @(negedge ace_aclk);
    endtask

    task automatic test_basic;
        int r, d, l;
        eng_hold = 0;
        start_sweep(44'h0_1000_0040, 32'd192, 32'd0);
        chk("t1_first_cycle_trigger", 64'(o_trigger), 64'd1);
        chk("t1_first_cycle_busy", 64'(o_busy), 64'd1);
        run_sweep("t1", 0, 0, -1, r, d, l);
        chk("t1_rises", 64'(r), 64'd3);
        chk("t1_dones", 64'(d), 64'd1);
        chk("t1_lines_done", 64'(o_lines_done), 64'd3);
        chk("t1_aborted", 64'(o_aborted), 64'd0);
        chk("t1_busy_end", 64'(o_busy), 64'd0);
        chk("t1_release_only_gap", 64'(l), 64'd1);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
`ifndef SWEEP_WATCHDOG_EN
        chk("t1_timeout_off", 64'(o_timeout), 64'd0);
`endif
    endtask

    task automatic test_ceil_align;
        int r, d, l;
        start_sweep(44'h0_1000_0000, 32'd100, 32'd0);
        run_sweep("t2_ceil", 0, 0, -1, r, d, l);
        chk("t2_ceil_rises", 64'(r), 64'd2);
        chk("t2_ceil_lines", 64'(o_lines_done), 64'd2);
        start_sweep(44'h0_1000_0013, 32'd64, 32'd0);
        run_sweep("t2_align", 0, 0, -1, r, d, l);
        chk("t2_align_rises", 64'(r), 64'd1);
        start_sweep(44'hFFF_FFFF_FFC0, 32'd128, 32'd1);
        run_sweep("t2_wrap", 0, 0, -1, r, d, l);
        chk("t2_wrap_rises", 64'(r), 64'd2);
        chk("t2_wrap_aborted", 64'(o_aborted), 64'd0);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic test_zero_size;
        i_base_addr = 44'h0_2000_0000; i_addr_size = 0; i_delay = 0; i_start = 1;
        @(negedge ace_aclk);
        i_start = 0;
        chk("t3_done_pulse", 64'(o_done), 64'd1);
        chk("t3_no_trigger", 64'(o_trigger), 64'd0);
        chk("t3_not_busy", 64'(o_busy), 64'd0);
        chk("t3_lines_cleared", 64'(o_lines_done), 64'd0);
        @(negedge ace_aclk);
        chk("t3_done_one_cycle", 64'(o_done), 64'd0);
        chk("t3_still_no_trigger", 64'(o_trigger), 64'd0);
    endtask

    task automatic test_gap;
        int r, d, l;
        // Trigger-low run = one release cycle + delay gap cycles.
        start_sweep(44'h0_3000_0000, 32'd256, 32'd10);
        run_sweep("t4_d10", 0, 0, -1, r, d, l);
        chk("t4_d10_rises", 64'(r), 64'd4);
        chk("t4_d10_low_cycles", 64'(l), 64'd11);
        // Engine busy 4 cycles past reply: release stretches to 4 cycles.
        eng_hold = 4;
        start_sweep(44'h0_3000_1000, 32'd128, 32'd2);
        run_sweep("t4_hold", 0, 0, -1, r, d, l);
        chk("t4_hold_low_cycles", 64'(l), 64'd6);
        chk("t4_hold_lines", 64'(o_lines_done), 64'd2);
        eng_hold = 0;
    endtask

    task automatic test_stop;
        int r, d, l;
        // Stop inside the wait of line 2 of 8.
        start_sweep(44'h0_4000_0000, 32'd512, 32'd0);
        run_sweep("t5_wait", 2, 2, -1, r, d, l);
        chk("t5_wait_rises", 64'(r), 64'd2);
        chk("t5_wait_lines", 64'(o_lines_done), 64'd2);
        chk("t5_wait_aborted", 64'(o_aborted), 64'd1);
        chk("t5_wait_dones", 64'(d), 64'd1);
        exp_q.delete();
        // Stop in the same cycle as the reply of line 2.
        start_sweep(44'h0_4000_0000, 32'd512, 32'd0);
        run_sweep("t5_same", 2, 6, -1, r, d, l);
        chk("t5_same_lines", 64'(o_lines_done), 64'd2);
        chk("t5_same_rises", 64'(r), 64'd2);
        exp_q.delete();
        // Stop during the gap after line 1.
        start_sweep(44'h0_4000_0000, 32'd256, 32'd20);
        run_sweep("t5_gap", 1, 15, -1, r, d, l);
        chk("t5_gap_rises", 64'(r), 64'd1);
        chk("t5_gap_lines", 64'(o_lines_done), 64'd1);
        chk("t5_gap_aborted", 64'(o_aborted), 64'd1);
        exp_q.delete();
        // Maximum size must still yield lines (no overflow to zero).
        start_sweep(44'h0_5000_0000, 32'hFFFF_FFFF, 32'd0);
        run_sweep("t5_max", 1, 2, -1, r, d, l);
        chk("t5_max_rises", 64'(r), 64'd1);
        chk("t5_max_lines", 64'(o_lines_done), 64'd1);
        exp_q.delete();
        // Stop while idle is ignored; new sweep clears aborted.
        i_stop = 1;
        @(negedge ace_aclk);
        i_stop = 0;
        start_sweep(44'h0_5000_0000, 32'd64, 32'd0);
        run_sweep("t5_idle_stop", 0, 0, -1, r, d, l);
        chk("t5_idle_stop_aborted", 64'(o_aborted), 64'd0);
        chk("t5_idle_stop_lines", 64'(o_lines_done), 64'd1);
    endtask

    task automatic test_start_while_busy;
        int r, d, l;
        start_sweep(44'h0_6000_0000, 32'd128, 32'd3);
        run_sweep("busy_start", 0, 0, 3, r, d, l);
        chk("busy_start_rises", 64'(r), 64'd2);
        chk("busy_start_lines", 64'(o_lines_done), 64'd2);
        chk("busy_start_dones", 64'(d), 64'd1);
        chk("busy_start_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic test_reset_mid_wait;
        start_sweep(44'h0_7000_0000, 32'd256, 32'd0);
        repeat (3) @(negedge ace_aclk);
        chk("t6_in_wait_trigger", 64'(o_trigger), 64'd1);
        ace_aresetn = 0;
        #1;
        chk("t6_trigger_drops", 64'(o_trigger), 64'd0);
        @(negedge ace_aclk);
        total++;
        if ({o_trigger, o_busy, o_done, o_aborted, o_timeout, o_line_addr, o_lines_done} !== '0) begin
            bad++;
            $display("FAIL t6_reset_outputs: got busy=%b addr=%h n=%0d want all 0",
                     o_busy, o_line_addr, o_lines_done);
        end
        ace_aresetn = 1;
        exp_q.delete();
        @(negedge ace_aclk);
    endtask

`ifdef SWEEP_WATCHDOG_EN
    task automatic test_watchdog;
        int cyc;
        bit hit;
        eng_en = 0;
        start_sweep(44'h0_7000_0000, 32'd64, 32'd0);
        exp_q.delete();
        hit = 0;
        for (cyc = 0; cyc < 70000; cyc++) begin
            if (o_timeout) begin hit = 1; break; end
            @(negedge ace_aclk);
        end
        total++;
        if (!hit || cyc < 65530 || cyc > 65545) begin
            bad++;
            $display("FAIL wdog_cycles: got hit=%0d after %0d cycles want ~65537", hit, cyc);
        end
        chk("wdog_aborted", 64'(o_aborted), 64'd1);
        chk("wdog_done", 64'(o_done), 64'd1);
        chk("wdog_trigger_low", 64'(o_trigger), 64'd0);
        eng_en = 1;
        @(negedge ace_aclk);
        chk("wdog_idle", 64'(o_busy), 64'd0);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_ceil_align;
        test_zero_size;
        test_gap;
        test_stop;
        test_start_while_busy;
        test_reset_mid_wait;
`ifdef SWEEP_WATCHDOG_EN
        test_watchdog;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
